mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
// - Multicycle MIPS core: the next-generation replacement for our single-cycle core. One unified memory port with a ready handshake (wait states), so instr/data share one memory.
// - Executes ADD/SUB/AND/OR/SLT, LW, SW, BEQ, BNE, ADDI, J. Adds retire/halt status for the bench.
// - Sits under top in place of the single-cycle core plus split imem/dmem.
// PARAMETERS
// - RESET_PC         32'h0000_0000  PC value loaded by reset
// - ADDR_W           32             byte-address bits driven on mem_addr (2..32); upper PC bits kept internally
// - HALT_ON_ILLEGAL  1              1: illegal op/funct -> HALT state; 0: retire as NOP
// PORTS
// - clk        in   1       rising-edge clock
// - reset      in   1       synchronous, active-high
// - mem_req    out  1       memory transaction request
// - mem_we     out  1       1 = write (SW), 0 = read
// - mem_addr   out  ADDR_W  byte address, bits [1:0] always 2'b00
// - mem_wdata  out  32      store data (rt)
// - mem_rdata  in   32      read data, valid in the cycle mem_req & mem_ready
// - mem_ready  in   1       completes the transfer in the current cycle
// - retire     out  1       1-cycle pulse in the last cycle of each instruction
// - halted     out  1       high while in HALT
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. While reset=1: mem_req=0, mem_we=0, retire=0, halted=0. Next edge: state=FETCH, pc=RESET_PC, IR=0.
//   Register contents are not reset; $0 always reads 0, writes to it ignored.
// - Reset dominates every other event, including mem_ready in the same cycle. Reset mid-transaction abandons it; no reg/pc update.
// - Handshake: mem_req/mem_we/mem_addr/mem_wdata decoded from state, stable until mem_ready=1. Transfer happens on the edge closing a cycle with req&ready.
//   Request held any number of cycles while ready=0. mem_ready ignored when mem_req=0.
// - States and transitions:
//   FETCH   req rd @pc; on ready: IR<=rdata, pc<=pc+4 -> DECODE
//   DECODE  A<=rs, B<=rt, ALUOut<=pc+(sext(imm)<<2); dispatch on op:
//           LW/SW->MEMADR, R->EXEC, BEQ/BNE->BRANCH, ADDI->ADDIEX, J->JUMP, illegal->HALT|FETCH(retire)
//   MEMADR  ALUOut<=A+sext(imm) -> LW:MEMRD, SW:MEMWR
//   MEMRD   req rd @ALUOut; on ready: MDR<=rdata -> MEMWB
//   MEMWB   rt<=MDR, retire -> FETCH
//   MEMWR   req wr @ALUOut, wdata=B; on ready: retire -> FETCH
//   EXEC    ALUOut<=A op B -> ALUWB
//   ALUWB   rd<=ALUOut, retire -> FETCH
//   ADDIEX  ALUOut<=A+sext(imm) -> IMMWB
//   IMMWB   rt<=ALUOut, retire -> FETCH
//   BRANCH  taken (BEQ:A==B, BNE:A!=B): pc<=ALUOut; retire -> FETCH
//   JUMP    pc<={pc[31:28],IR[25:0],2'b00}; retire -> FETCH
//   HALT    terminal: no req, halted=1; left only by reset
// - Latency at ready=1: FETCH 1 cycle; J/BEQ/BNE 3; R/ADDI/SW 4; LW 5. Each wait cycle adds 1.
// - Arithmetic: 32-bit wraparound, no overflow trap. SLT signed compare. Branch offset sign-extended, shifted 2, added to pc+4.
//   mem_addr = pc/ALUOut truncated to ADDR_W.
// STRUCTURE
// - Package mips_pkg: opcode/funct localparams, ALU control codes (ADD 010, SUB 110, AND 000, OR 001, SLT 111), state encoding.
// - Sub-module mips_mc_regfile: 32x32, two combinational reads, one sync write, $0 hardwired 0.
// - FSM, ALU, IR/MDR/A/B/ALUOut registers and pc live in mips_multicycle_core.
// TESTING
// - Reset, mem returns ADDI $2,$0,5 (0x20020005), ready=1 -> retire on 4th cycle, $2=5, pc=4, mem_req high again in cycle 5.
// - LW $3,4($0) with ready low 3 cycles in MEMRD -> mem_addr=4 held stable; $3=rdata; retire on cycle 8 after fetch.
// - BEQ $0,$0,-2 at pc=8 -> pc=4, retire 3rd cycle. BNE $0,$0,-2 -> pc=12.
// - Standard regression program on zero-wait memory -> mem_we write with mem_addr=84, mem_wdata=7; no other write except addr 80.
// - Op 6'h3F, HALT_ON_ILLEGAL=1 -> halted=1, mem_req=0 for 20 cycles. Same with param=0 -> retire, pc+=4.
// - Reset asserted while MEMWR stalled -> no write occurs, next cycle FETCH at RESET_PC, halted=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Opcodes, functs, ALU control codes, FSM state encoding and ALU
//               helpers for the multicycle MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [2:0] c_alu_and  = 3'b000;
    localparam logic [2:0] c_alu_or   = 3'b001;
    localparam logic [2:0] c_alu_add  = 3'b010;
    localparam logic [2:0] c_alu_sub  = 3'b110;
    localparam logic [2:0] c_alu_slt  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == c_fn_add) || (funct == c_fn_sub) || (funct == c_fn_and) ||
               (funct == c_fn_or)  || (funct == c_fn_slt);
    endfunction

    function automatic logic [2:0] alu_ctrl(input logic [5:0] funct);
        logic [2:0] ctrl;
        case (funct)
            c_fn_sub: ctrl = c_alu_sub;
            c_fn_and: ctrl = c_alu_and;
            c_fn_or:  ctrl = c_alu_or;
            c_fn_slt: ctrl = c_alu_slt;
            default:  ctrl = c_alu_add;
        endcase
        return ctrl;
    endfunction

    function automatic logic [31:0] alu_op(input logic [2:0] ctrl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] y;
        case (ctrl)
            c_alu_add: y = a + b;
            c_alu_sub: y = a - b;
            c_alu_and: y = a & b;
            c_alu_or:  y = a | b;
            c_alu_slt: y = {31'd0, $signed(a) < $signed(b)};
            default:   y = '0;
        endcase
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mem_if.sv
// ============================================================================
// Module      : mips_mem_if
// Description : Unified instruction/data memory port with ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_mem_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/mips_mc_regfile.sv
// ============================================================================
// Module      : mips_mc_regfile
// Description : 32x32 register file, two combinational reads, one synchronous
//               write; register 0 reads as zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_regfile (
    input  wire logic        clk,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_waddr,
    input  wire logic [31:0] i_wdata,
    input  wire logic [4:0]  i_raddr1,
    input  wire logic [4:0]  i_raddr2,
    output logic      [31:0] o_rdata1,
    output logic      [31:0] o_rdata2
);
    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];
endmodule

`default_nettype wire

// File: rtl/mips_multicycle_core.sv
// ============================================================================
// Module      : mips_multicycle_core
// Description : Multicycle MIPS core sharing one memory port for instruction
//               fetch and data access, with retire/halt status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter int          HALT_ON_ILLEGAL = 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mips_mem_if.master  mem,
    output logic        retire,
    output logic        halted
);
    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext, w_rs_data, w_rt_data;
    logic [31:0] w_addr_full, w_addr_aligned;
    logic        w_illegal, w_rf_we, w_wb_alu;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};

    always_comb begin
        w_illegal = 1'b1;
        case (w_op)
            c_op_rtype: w_illegal = !funct_legal(w_funct);
            c_op_lw, c_op_sw, c_op_beq, c_op_bne, c_op_addi, c_op_j: w_illegal = 1'b0;
            default:    w_illegal = 1'b1;
        endcase
    end

    // Writeback is only ever taken from the three WB states; reset blocks it.
    assign w_wb_alu   = (r_state == S_ALUWB);
    assign w_rf_we    = !reset && ((r_state == S_MEMWB) || w_wb_alu || (r_state == S_IMMWB));
    assign w_rf_waddr = w_wb_alu ? w_rd : w_rt;
    assign w_rf_wdata = (r_state == S_MEMWB) ? r_mdr : r_aluout;

    mips_mc_regfile u_regfile (
        .clk      (clk),
        .i_we     (w_rf_we),
        .i_waddr  (w_rf_waddr),
        .i_wdata  (w_rf_wdata),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_data),
        .o_rdata2 (w_rt_data)
    );

    assign w_addr_full    = (r_state == S_FETCH) ? r_pc : r_aluout;
    assign w_addr_aligned = {w_addr_full[31:2], 2'b00};

    assign mem.mem_req   = !reset && ((r_state == S_FETCH) || (r_state == S_MEMRD) ||
                                      (r_state == S_MEMWR));
    assign mem.mem_we    = !reset && (r_state == S_MEMWR);
    assign mem.mem_addr  = w_addr_aligned[ADDR_W-1:0];
    assign mem.mem_wdata = r_b;

    assign retire = !reset && ((r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                               (r_state == S_IMMWB) || (r_state == S_BRANCH) ||
                               (r_state == S_JUMP)  ||
                               ((r_state == S_MEMWR) && mem.mem_ready) ||
                               ((r_state == S_DECODE) && w_illegal && (HALT_ON_ILLEGAL == 0)));
    assign halted = !reset && (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        r_ir    <= mem.mem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rs_data;
                    r_b      <= w_rt_data;
                    r_aluout <= r_pc + {w_sext[29:0], 2'b00};
                    if (w_illegal) begin
                        r_state <= (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                    end else begin
                        case (w_op)
                            c_op_lw, c_op_sw:   r_state <= S_MEMADR;
                            c_op_beq, c_op_bne: r_state <= S_BRANCH;
                            c_op_addi:          r_state <= S_ADDIEX;
                            c_op_j:             r_state <= S_JUMP;
                            default:            r_state <= S_EXEC;
                        endcase
                    end
                end
                S_MEMADR: begin
                    r_aluout <= r_a + w_sext;
                    r_state  <= (w_op == c_op_lw) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem.mem_ready) begin
                        r_mdr   <= mem.mem_rdata;
                        r_state <= S_MEMWB;
                    end
                end
                S_MEMWR: begin
                    if (mem.mem_ready) begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_aluout <= alu_op(alu_ctrl(w_funct), r_a, r_b);
                    r_state  <= S_ALUWB;
                end
                S_ADDIEX: begin
                    r_aluout <= r_a + w_sext;
                    r_state  <= S_IMMWB;
                end
                S_BRANCH: begin
                    // BEQ takes on equality, BNE on inequality.
                    if ((w_op == c_op_beq) == (r_a == r_b)) begin
                        r_pc <= r_aluout;
                    end
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
// ============================================================================
// Module      : tb_mips_multicycle_core
// Description : Scoreboard bench: expected memory transfers and retire cycles
//               are queued by the stimulus and popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_multicycle_core;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    logic retire, halted, retire2, halted2;

    mips_mem_if bus ();
    mips_mem_if bus2 ();

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .reset(reset), .mem(bus), .retire(retire), .halted(halted));

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_ON_ILLEGAL(0)) dut2 (
        .clk(clk), .reset(reset2), .mem(bus2), .retire(retire2), .halted(halted2));

    always #5 clk = ~clk;

    logic [31:0] prog  [0:63];
    logic [31:0] dmem  [0:63];
    logic        dvalid[0:63];
    logic [5:0]  w_idx;
    assign w_idx         = bus.mem_addr[7:2];
    assign bus.mem_rdata = dvalid[w_idx] ? dmem[w_idx] : prog[w_idx];
    assign bus2.mem_ready = 1'b1;
    assign bus2.mem_rdata = 32'hFC00_0000;

    int total = 0, bad = 0, cyc = 0, retire_cnt = 0, wr_cnt = 0;
    int stall_cnt = 0, stall_used = 0;
    logic [31:0] stall_addr = '0;
    logic        stall_we   = 1'b0;
    bit          chk_rd = 1'b1, chk_ret = 1'b1;
    xfer_t       exp_q[$];
    int          exp_ret_q[$];
    xfer_t       m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [31:0] a);
        exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    // Memory responder: optional wait states on one address/direction.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            stall_used    = 0;
            bus.mem_ready = 1'b1;
        end else if (bus.mem_req && (bus.mem_we == stall_we) &&
                     (bus.mem_addr == stall_addr) && (stall_used < stall_cnt)) begin
            bus.mem_ready = 1'b0;
            stall_used++;
        end else begin
            bus.mem_ready = 1'b1;
        end
    end

    // Monitor: transfer and retire checking against the queues.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            cyc = 0;
            for (int i = 0; i < 64; i++) dvalid[i] = 1'b0;
        end else begin
            cyc++;
            if (bus.mem_req && bus.mem_ready) begin
                if (bus.mem_we) begin
                    dmem[w_idx]   = bus.mem_wdata;
                    dvalid[w_idx] = 1'b1;
                    wr_cnt++;
                end
                if (bus.mem_we || chk_rd) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_xfer: actual we=%b addr=%h required none",
                                 bus.mem_we, bus.mem_addr);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("xfer_we", {31'd0, bus.mem_we}, {31'd0, m_e.we});
                        check("xfer_addr", bus.mem_addr, m_e.addr);
                        if (m_e.we) check("xfer_wdata", bus.mem_wdata, m_e.data);
                    end
                end
            end
            if (retire) begin
                retire_cnt++;
                if (chk_ret) begin
                    if (exp_ret_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_retire: actual cycle=%0d required none", cyc);
                    end else begin
                        check("retire_cycle", cyc, exp_ret_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic start_test();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        exp_ret_q.delete();
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) prog[i] = 32'hFC00_0000;
    endtask

    task automatic release_reset();
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int k = 0;
        while (cyc != n && k < 1000) begin
            @(negedge clk); #3;
            k++;
        end
        if (cyc != n) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: actual cycle=%0d required %0d", cyc, n);
        end
    endtask

    task automatic wait_halt(input string name, input int limit);
        int k = 0;
        while (!halted && k < limit) begin
            @(negedge clk); #3;
            k++;
        end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_xfer_q_empty"}, exp_q.size(), 0);
        check({name, "_retire_q_empty"}, exp_ret_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad, r0, w0;
        bus.mem_ready = 1'b1;

        // ADDI $2,$0,5 then SW $2,0x40($0), then illegal op halts
        start_test();
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        prog[0] = 32'h2002_0005;
        prog[1] = 32'hAC02_0040;
        exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h40, 32'd5); exp_rd(32'h8);
        exp_ret_q.push_back(4); exp_ret_q.push_back(8);
        release_reset();
        wait_cyc(5);
        check("addi_next_fetch_req", {31'd0, bus.mem_req}, 32'd1);
        check("addi_next_fetch_addr", bus.mem_addr, 32'h4);
        wait_halt("addi_halt", 50);
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (!halted || bus.mem_req) n_bad++;
        end
        check("halt_hold_cycles_bad", n_bad, 0);
        check_drained("addi");

        // LW $3,4($0) with three wait states, then SW $3,0x44($0)
        start_test();
        prog[0] = 32'h8C03_0004;
        prog[1] = 32'hAC03_0044;
        stall_addr = 32'h4; stall_we = 1'b0; stall_cnt = 3;
        exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h4); exp_wr(32'h44, 32'hAC03_0044); exp_rd(32'h8);
        exp_ret_q.push_back(8); exp_ret_q.push_back(12);
        release_reset();
        for (int c = 4; c <= 7; c++) begin
            wait_cyc(c);
            check("lw_stall_req", {31'd0, bus.mem_req}, 32'd1);
            check("lw_stall_addr", bus.mem_addr, 32'h4);
        end
        wait_halt("lw_halt", 100);
        check_drained("lw");

        // J to 8, BEQ $0,$0,-2 -> 4 (illegal there)
        start_test();
        prog[0] = 32'h0800_0002;
        prog[2] = 32'h1000_FFFE;
        exp_rd(32'h0); exp_rd(32'h8); exp_rd(32'h4);
        exp_ret_q.push_back(3); exp_ret_q.push_back(6);
        release_reset();
        wait_halt("beq_halt", 100);
        check_drained("beq");

        // J to 8, BNE $0,$0,-2 not taken -> 12
        start_test();
        prog[0] = 32'h0800_0002;
        prog[2] = 32'h1400_FFFE;
        exp_rd(32'h0); exp_rd(32'h8); exp_rd(32'hC);
        exp_ret_q.push_back(3); exp_ret_q.push_back(6);
        release_reset();
        wait_halt("bne_halt", 100);
        check_drained("bne");

        // Regression program: only writes are tracked
        start_test();
        chk_rd = 1'b0; chk_ret = 1'b0;
        prog[0]  = 32'h2002_0005; prog[1]  = 32'h2003_000C; prog[2]  = 32'h2067_FFF7;
        prog[3]  = 32'h00E2_2025; prog[4]  = 32'h0064_2824; prog[5]  = 32'h00A4_2820;
        prog[6]  = 32'h10A7_000A; prog[7]  = 32'h0064_202A; prog[8]  = 32'h1080_0001;
        prog[9]  = 32'h2005_0000; prog[10] = 32'h00E2_202A; prog[11] = 32'h0085_3820;
        prog[12] = 32'h00E2_3822; prog[13] = 32'hAC67_0044; prog[14] = 32'h8C02_0050;
        prog[15] = 32'h0800_0011; prog[16] = 32'h2002_0001; prog[17] = 32'hAC02_0054;
        exp_wr(32'd80, 32'd7); exp_wr(32'd84, 32'd7);
        r0 = retire_cnt;
        release_reset();
        wait_halt("regr_halt", 400);
        check("regr_retire_count", retire_cnt - r0, 16);
        check_drained("regr");
        chk_rd = 1'b1; chk_ret = 1'b1;

        // Reset while SW $0,0x40($0) is stalled: write abandoned
        start_test();
        prog[0] = 32'hAC00_0040;
        stall_addr = 32'h40; stall_we = 1'b1; stall_cnt = 10;
        exp_rd(32'h0);
        release_reset();
        wait_cyc(6);
        check("sw_stall_we", {31'd0, bus.mem_we}, 32'd1);
        check("sw_stall_addr", bus.mem_addr, 32'h40);
        w0 = wr_cnt;
        @(posedge clk); #1 reset = 1'b1;
        #1 check("sw_rst_req", {31'd0, bus.mem_req}, 32'd0);
        stall_cnt = 0;
        exp_rd(32'h0); exp_wr(32'h40, 32'h0); exp_rd(32'h4);
        exp_ret_q.push_back(4);
        release_reset();
        @(negedge clk); #3;
        check("sw_rst_fetch_addr", bus.mem_addr, 32'h0);
        check("sw_rst_fetch_we", {31'd0, bus.mem_we}, 32'd0);
        check("sw_rst_halted", {31'd0, halted}, 32'd0);
        check("sw_rst_no_write", wr_cnt - w0, 0);
        wait_halt("sw_rst_halt", 100);
        check_drained("sw_rst");

        // HALT_ON_ILLEGAL=0: illegal op retires as NOP, pc advances
        check("nop_rst_req", {31'd0, bus2.mem_req}, 32'd0);
        @(posedge clk); #1 reset2 = 1'b0;
        @(negedge clk); #3;
        check("nop_c1_addr", bus2.mem_addr, 32'h0);
        check("nop_c1_retire", {31'd0, retire2}, 32'd0);
        @(negedge clk); #3;
        check("nop_c2_retire", {31'd0, retire2}, 32'd1);
        check("nop_c2_halted", {31'd0, halted2}, 32'd0);
        @(negedge clk); #3;
        check("nop_c3_req", {31'd0, bus2.mem_req}, 32'd1);
        check("nop_c3_we", {31'd0, bus2.mem_we}, 32'd0);
        check("nop_c3_addr", bus2.mem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
